// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage: exception codes,
// bus word types and the fetch FSM state encoding.
package if_fetch_unit_pkg;

  localparam int EXC_W = 5;
  typedef logic [EXC_W-1:0] exc_bus_t;
  localparam exc_bus_t EXC_NO_EXC = 5'h00;
  localparam exc_bus_t EXC_ADEL   = 5'h04;

  typedef logic [31:0] addr_bus_t;
  typedef logic [31:0] data_bus_t;
  localparam data_bus_t ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_S_REQ    = 2'd0,
    IF_S_WAIT   = 2'd1,
    IF_S_DONE   = 2'd2,
    IF_S_CANCEL = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// MIPS32 instruction-fetch stage: owns the PC, drives a req/addr_ok/data_ok
// instruction bus, and redirects on flush or on a taken branch after its delay slot.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter addr_bus_t RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  addr_bus_t   flush_pc,
  input  logic        br_flag,
  input  addr_bus_t   br_target,
  output logic        ibus_req,
  output addr_bus_t   ibus_addr,
  input  logic        ibus_addr_ok,
  input  logic        ibus_data_ok,
  input  data_bus_t   ibus_rdata,
  output addr_bus_t   if_pc,
  output addr_bus_t   if_pcp4,
  output data_bus_t   if_inst,
  output exc_bus_t    if_excp,
  output logic        if_stallreq,
  output if_state_e   if_state
);

  // Bus handshake: a request is transferred in a cycle where ibus_req and
  // ibus_addr_ok are both high; its data arrives in a later cycle flagged by
  // ibus_data_ok. An unaccepted request may be dropped at any time.

  if_state_e state_q, state_d;
  addr_bus_t pc_q, pc_d;
  logic      br_pend_q, br_pend_d;
  addr_bus_t br_tgt_q, br_tgt_d;
  data_bus_t inst_buf_q, inst_buf_d;

  logic      pc_misaligned;
  logic      inst_valid;
  logic      advance;
  addr_bus_t next_pc;

  assign pc_misaligned = (pc_q[1:0] != 2'b00);
  assign ibus_addr     = pc_q;
  assign if_pc         = pc_q;
  assign if_pcp4       = pc_q + 32'd4;
  assign if_state      = state_q;

  always_comb begin
    inst_valid  = 1'b0;
    ibus_req    = 1'b0;
    if_inst     = ZERO_WORD;
    if_excp     = EXC_NO_EXC;
    if_stallreq = 1'b1;
    if (!rst) begin
      case (state_q)
        IF_S_REQ: begin
          if (pc_misaligned) begin
            inst_valid  = 1'b1;
            if_excp     = EXC_ADEL;
            if_stallreq = 1'b0;
          end else begin
            ibus_req = 1'b1;
          end
        end
        IF_S_WAIT: begin
          if (ibus_data_ok) begin
            inst_valid  = 1'b1;
            if_inst     = ibus_rdata;
            if_stallreq = 1'b0;
          end
        end
        IF_S_DONE: begin
          inst_valid  = 1'b1;
          if_inst     = inst_buf_q;
          if_stallreq = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign advance = inst_valid && !stall && !flush;
  // A branch seen in this very cycle wins over one latched while the slot was in flight.
  assign next_pc = br_flag ? br_target : (br_pend_q ? br_tgt_q : pc_q + 32'd4);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    br_pend_d  = br_pend_q;
    br_tgt_d   = br_tgt_q;
    inst_buf_d = inst_buf_q;
    if (flush) begin
      pc_d      = flush_pc;
      br_pend_d = 1'b0;
      case (state_q)
        IF_S_REQ:    state_d = (ibus_req && ibus_addr_ok) ? IF_S_CANCEL : IF_S_REQ;
        IF_S_WAIT:   state_d = ibus_data_ok ? IF_S_REQ : IF_S_CANCEL;
        IF_S_CANCEL: state_d = ibus_data_ok ? IF_S_REQ : IF_S_CANCEL;
        default:     state_d = IF_S_REQ;
      endcase
    end else if (advance) begin
      pc_d      = next_pc;
      br_pend_d = 1'b0;
      state_d   = IF_S_REQ;
    end else begin
      if (br_flag) begin
        br_pend_d = 1'b1;
        br_tgt_d  = br_target;
      end
      case (state_q)
        IF_S_REQ: if (ibus_req && ibus_addr_ok) state_d = IF_S_WAIT;
        IF_S_WAIT: begin
          if (ibus_data_ok) begin
            inst_buf_d = ibus_rdata;
            state_d    = IF_S_DONE;
          end
        end
        IF_S_CANCEL: if (ibus_data_ok) state_d = IF_S_REQ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IF_S_REQ;
      pc_q       <= RESET_PC;
      br_pend_q  <= 1'b0;
      br_tgt_q   <= ZERO_WORD;
      inst_buf_q <= ZERO_WORD;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      br_pend_q  <= br_pend_d;
      br_tgt_q   <= br_tgt_d;
      inst_buf_q <= inst_buf_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: sequential fetch, stall buffering, delay-slot
// branch, flush/cancel, misaligned PC, reset mid-transaction and PC wrap.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        br_flag;
  logic [31:0] br_target;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_addr_ok;
  logic        ibus_data_ok;
  logic [31:0] ibus_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_pcp4;
  logic [31:0] if_inst;
  exc_bus_t    if_excp;
  logic        if_stallreq;
  if_state_e   if_state;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  if_fetch_unit #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .br_flag(br_flag), .br_target(br_target), .ibus_req(ibus_req),
    .ibus_addr(ibus_addr), .ibus_addr_ok(ibus_addr_ok), .ibus_data_ok(ibus_data_ok),
    .ibus_rdata(ibus_rdata), .if_pc(if_pc), .if_pcp4(if_pcp4), .if_inst(if_inst),
    .if_excp(if_excp), .if_stallreq(if_stallreq), .if_state(if_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic a_ok, input logic d_ok, input logic [31:0] rd);
    ibus_addr_ok = a_ok;
    ibus_data_ok = d_ok;
    ibus_rdata   = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    drive(1'b1, 1'b0, 32'h0);
    check("acc_req", 32'(ibus_req), 32'd1);
    check("acc_stallreq", 32'(if_stallreq), 32'd1);
    if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else check("acc_addr", ibus_addr, exp_q.pop_front());
    tick();
  endtask

  task automatic deliver(input logic [31:0] rd);
    drive(1'b0, 1'b1, rd);
    check("dlv_stallreq", 32'(if_stallreq), 32'd0);
    check("dlv_inst", if_inst, rd);
    check("dlv_excp", 32'(if_excp), 32'(EXC_NO_EXC));
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = '0;
    br_flag = 1'b0; br_target = '0;
    ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0; ibus_rdata = '0;
    exp_q.push_back(32'hBFC0_0000); exp_q.push_back(32'hBFC0_0004);
    exp_q.push_back(32'hBFC0_0008); exp_q.push_back(32'hBFC0_000C);
    exp_q.push_back(32'hBFC0_0010); exp_q.push_back(32'h8000_0100);
    exp_q.push_back(32'h8000_0200); exp_q.push_back(32'h8000_0180);
    exp_q.push_back(32'h8000_0400); exp_q.push_back(32'hBFC0_0000);
    exp_q.push_back(32'hFFFF_FFFC);

    // Reset cycle outputs
    tick(); tick();
    drive(1'b0, 1'b0, 32'h0);
    check("rst_req", 32'(ibus_req), 32'd0);
    check("rst_stallreq", 32'(if_stallreq), 32'd1);
    check("rst_inst", if_inst, 32'h0);
    check("rst_excp", 32'(if_excp), 32'(EXC_NO_EXC));
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    check("post_rst_pc", if_pc, 32'hBFC0_0000);
    check("post_rst_pcp4", if_pcp4, 32'hBFC0_0004);
    check("post_rst_state", 32'(if_state), 32'(IF_S_REQ));

    // Back-to-back fetches, one instruction per two cycles
    accept(); deliver(32'h1111_0000);
    accept(); deliver(32'h2222_0004);
    accept(); deliver(32'h3333_0008);
    drive(1'b0, 1'b0, 32'h0);
    check("seq_pc", if_pc, 32'hBFC0_000C);

    // Stall across data_ok: instruction buffered in S_DONE
    accept();
    stall = 1'b1;
    deliver(32'h2401_0001);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      check("stl_state", 32'(if_state), 32'(IF_S_DONE));
      check("stl_req", 32'(ibus_req), 32'd0);
      check("stl_inst", if_inst, 32'h2401_0001);
      check("stl_stallreq", 32'(if_stallreq), 32'd0);
      check("stl_pc", if_pc, 32'hBFC0_000C);
      tick();
    end
    stall = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    check("stl_release_inst", if_inst, 32'h2401_0001);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    check("stl_next_pc", if_pc, 32'hBFC0_0010);

    // Branch in ID while delay slot waits: latched then applied
    br_flag = 1'b1; br_target = 32'h8000_0100;
    accept();
    drive(1'b0, 1'b0, 32'h0);
    check("br_wait_stallreq", 32'(if_stallreq), 32'd1);
    tick();
    br_flag = 1'b0; br_target = 32'h0;
    deliver(32'h0000_0000);
    drive(1'b0, 1'b0, 32'h0);
    check("br_pend_pc", if_pc, 32'h8000_0100);

    // Branch seen only in the advance cycle
    accept();
    br_flag = 1'b1; br_target = 32'h8000_0200;
    deliver(32'h4444_0100);
    br_flag = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    check("br_direct_pc", if_pc, 32'h8000_0200);

    // Flush with a response outstanding and a branch pending
    br_flag = 1'b1; br_target = 32'h8000_0300;
    accept();
    br_flag = 1'b0;
    flush = 1'b1; flush_pc = 32'h8000_0180;
    drive(1'b0, 1'b0, 32'h0);
    check("fl_stallreq", 32'(if_stallreq), 32'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, 1'b1, 32'hDEAD_BEEF);
    check("fl_cancel_state", 32'(if_state), 32'(IF_S_CANCEL));
    check("fl_cancel_stallreq", 32'(if_stallreq), 32'd1);
    check("fl_cancel_req", 32'(ibus_req), 32'd0);
    check("fl_pc", if_pc, 32'h8000_0180);
    tick();
    accept(); deliver(32'h5555_0180);
    drive(1'b0, 1'b0, 32'h0);
    check("fl_br_dropped_pc", if_pc, 32'h8000_0184);

    // Misaligned redirect raises AdEL without a bus request
    flush = 1'b1; flush_pc = 32'h8000_0182;
    drive(1'b0, 1'b0, 32'h0);
    tick();
    flush = 1'b0; stall = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    check("adel_req", 32'(ibus_req), 32'd0);
    check("adel_excp", 32'(if_excp), 32'(EXC_ADEL));
    check("adel_inst", if_inst, 32'h0);
    check("adel_pc", if_pc, 32'h8000_0182);
    check("adel_stallreq", 32'(if_stallreq), 32'd0);
    tick();
    stall = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    check("adel_adv_pc", if_pc, 32'h8000_0186);

    // Reset while waiting for data; late data_ok ignored
    flush = 1'b1; flush_pc = 32'h8000_0400;
    drive(1'b0, 1'b0, 32'h0);
    tick();
    flush = 1'b0;
    accept();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    check("mrst_req", 32'(ibus_req), 32'd0);
    check("mrst_stallreq", 32'(if_stallreq), 32'd1);
    check("mrst_inst", if_inst, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'hCAFE_F00D);
    check("stale_state", 32'(if_state), 32'(IF_S_REQ));
    check("stale_stallreq", 32'(if_stallreq), 32'd1);
    check("stale_pc", if_pc, 32'hBFC0_0000);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    check("stale_after_state", 32'(if_state), 32'(IF_S_REQ));
    accept(); deliver(32'h6666_0000);

    // 32-bit PC wrap
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    drive(1'b0, 1'b0, 32'h0);
    tick();
    flush = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    check("wrap_pcp4", if_pcp4, 32'h0000_0000);
    accept(); deliver(32'h7777_FFFC);
    drive(1'b0, 1'b0, 32'h0);
    check("wrap_pc", if_pc, 32'h0000_0000);

    check("sb_remaining", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the MIPS32 core. It owns the program counter and drives a request/response instruction bus. It presents `if_pc`, `if_pcp4`, `if_inst` and `if_excp` to the IF/ID pipeline register, and raises `if_stallreq` while no fetched instruction is available. It redirects on pipeline flush (exception/ERET target) and on taken branches resolved in ID, honouring the MIPS delay slot.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: PC loaded on reset.
- `clk` in, 1: single clock, all state updates on rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `stall` in, 1: pipeline hold; IF must not advance.
- `flush` in, 1: discard current fetch, redirect to `flush_pc`.
- `flush_pc` in, 32: redirect target, valid with `flush`.
- `br_flag` in, 1: taken branch/jump currently in ID.
- `br_target` in, 32: branch target, valid with `br_flag`.
- `ibus_req` out, 1: fetch request.
- `ibus_addr` out, 32: fetch address (= PC).
- `ibus_addr_ok` in, 1: request accepted this cycle.
- `ibus_data_ok` in, 1: read data returned this cycle.
- `ibus_rdata` in, 32: instruction word.
- `if_pc`, `if_pcp4` out, 32: current PC, PC+4.
- `if_inst` out, 32: fetched instruction (0 on exception).
- `if_excp` out, ExcBus: `Exc_NoExc` or `Exc_AdEL`.
- `if_stallreq` out, 1: no valid instruction this cycle.

## Operation
- States:
  - S_REQ: issue a request.
  - S_WAIT: request accepted, awaiting data.
  - S_DONE: instruction buffered, waiting out `stall`.
  - S_CANCEL: outstanding response must be discarded.
- "Advance" = valid instruction presented and `stall`=0. On advance: PC <= next_pc, state -> S_REQ.
- next_pc priority:
  - `br_flag` in the advance cycle: `br_target`.
  - else `br_pend`: `br_tgt`.
  - else PC+4.
- `br_flag` with no advance: latch `br_pend`=1, `br_tgt`=`br_target`. `br_pend` clears on advance.
- While the branch sits in ID, the fetch in flight is its delay slot. The redirect therefore applies to the fetch after the slot.
- S_REQ:
  - PC[1:0]≠0: no bus request. Present `if_inst`=0, `if_excp`=`Exc_AdEL`, `if_stallreq`=0. Advance rules apply as normal.
  - Otherwise: `ibus_req`=1, `ibus_addr`=PC. `ibus_addr_ok` moves to S_WAIT.
- S_WAIT:
  - `ibus_data_ok`: `if_inst`=`ibus_rdata` (bypass), `if_stallreq`=0. If `stall`=1, capture into `inst_buf` and go to S_DONE.
  - No `ibus_data_ok`: `if_stallreq`=1.
- S_DONE: `if_inst`=`inst_buf`, `if_stallreq`=0. Leaves on advance.
- S_CANCEL: `if_stallreq`=1, `ibus_req`=0. On `ibus_data_ok`, drop the data and go to S_REQ.
- flush (overrides `stall`, branch and advance):
  - PC <= `flush_pc`; `br_pend` <= 0.
  - State goes to S_CANCEL if a response is outstanding after this cycle: S_REQ with `ibus_addr_ok`, or S_WAIT without `ibus_data_ok`.
  - Otherwise state goes to S_REQ.
  - flush during S_CANCEL: update PC, stay in S_CANCEL, unless `ibus_data_ok` arrives the same cycle (then S_REQ).
- A request not yet accepted (no `addr_ok`) may be withdrawn; the bus tolerates `ibus_req` dropping.
- Bus assumption: at most one outstanding request. `data_ok` comes no earlier than the cycle after `addr_ok`.

## Timing
- Reset (`rst`=1 at an edge):
  - PC=`RESET_PC`, state=S_REQ, `br_pend`=0, `inst_buf`=0.
  - Outputs in the reset cycle: `ibus_req`=0, `if_stallreq`=1, `if_inst`=0, `if_excp`=`Exc_NoExc`.
  - After reset: `if_pc`=`RESET_PC`, `if_pcp4`=`RESET_PC`+4.
- Reset mid-transaction: state returns to S_REQ. A stale `data_ok` arriving in S_REQ is ignored.
- Request-to-valid latency: 1 cycle after `addr_ok` at minimum, with the instruction bypassed in the `data_ok` cycle. Peak throughput is 1 instruction per 2 cycles.
- `if_stallreq` is combinational from state and `ibus_data_ok`. `ibus_req` is combinational from state, PC alignment and `rst`.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.

## Structure
- Shared defines file holds:
  - `ExcBus` width, `Exc_NoExc`, `Exc_AdEL`.
  - `AddrBus`, `DataBus`, `ZeroWord`.
  - The state encodings: `IF_S_REQ`, `IF_S_WAIT`, `IF_S_DONE`, `IF_S_CANCEL`.
- Single module; no sub-module warranted.

## Test plan
- Reset release, bus with `addr_ok` immediate and `data_ok` one cycle later, `stall`=0 → `ibus_addr` BFC00000, BFC00004, BFC00008 on alternating cycles; `if_stallreq` low exactly in the `data_ok` cycles.
- `stall`=1 for 3 cycles spanning `data_ok` (rdata 0x24010001) → S_DONE holds `if_inst`=0x24010001; no new request until `stall` drops; PC unchanged.
- `br_flag`=1, `br_target`=0x80000100 while the delay slot at BFC00008 is in S_WAIT → the fetch after BFC00008 requests 0x80000100, not BFC0000C.
- flush (`flush_pc`=0x80000180) one cycle after `addr_ok`, before `data_ok` → returned data dropped, `if_stallreq` stays 1, next request 0x80000180; a pending branch is discarded.
- `flush_pc`=0x80000182 → no `ibus_req`; `if_excp`=`Exc_AdEL`, `if_inst`=0, `if_pc`=0x80000182, `if_stallreq`=0.
- `rst` asserted while in S_WAIT, then released → `ibus_req`=0 in the reset cycle; a late `data_ok` is ignored; next request BFC00000.
